// File: rtl/msrv32_wb_queue_unit.sv
// Writeback stage: source select feeding a DEPTH-entry pending-write FIFO that drains into the register file.
// Optional forwarding lookup over pending entries is built when MSRV32_WB_FWD_EN is defined.
module msrv32_wb_queue_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 6,
  parameter int SEL_W   = 3,
  parameter int DEPTH   = 2,
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                    ms_riscv32_mp_clk_in,
  input  logic                    ms_riscv32_mp_rst_in,
  input  logic                    wb_valid_in,
  output logic                    wb_ready_out,
  input  logic [SEL_W-1:0]        wb_mux_sel_in,
  input  logic [NUM_SRC*XLEN-1:0] src_data_in,
  input  logic [4:0]              rd_addr_in,
  output logic                    rf_wr_en_out,
  output logic [4:0]              rf_rd_addr_out,
  output logic [XLEN-1:0]         rf_wr_data_out,
  input  logic                    rf_wr_ack_in,
  output logic [CNT_W-1:0]        wb_count_out,
  input  logic [4:0]              fwd_addr_in,
  output logic                    fwd_hit_out,
  output logic [XLEN-1:0]         fwd_data_out
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       rd_mem_q   [DEPTH];
  logic [XLEN-1:0]  data_mem_q [DEPTH];

  logic [XLEN-1:0]  sel_data;
  logic             push;
  logic             pop;
  logic             head_en;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input int off);
    int s;
    s = int'(p) + off;
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Out-of-range selects fall back to the ALU result in slot 0.
  always_comb begin
    sel_data = src_data_in[0 +: XLEN];
    for (int k = 1; k < NUM_SRC; k++) begin
      if (wb_mux_sel_in == SEL_W'(k)) sel_data = src_data_in[k*XLEN +: XLEN];
    end
  end

  assign wb_ready_out = (count_q != CNT_W'(DEPTH));
  assign push         = wb_valid_in && wb_ready_out && (rd_addr_in != 5'd0) && !ms_riscv32_mp_rst_in;
  // The head is suppressed during reset so no write escapes in the reset cycle.
  assign head_en      = (count_q != '0) && !ms_riscv32_mp_rst_in;
  assign pop          = head_en && rf_wr_ack_in;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (pop) begin
      rd_ptr_d          = ptr_inc(rd_ptr_q);
      valid_d[rd_ptr_q] = 1'b0;
    end
    if (push) begin
      wr_ptr_d          = ptr_inc(wr_ptr_q);
      valid_d[wr_ptr_q] = 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Payload storage needs no reset; the valid bits and count gate every read of it.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) begin
      rd_mem_q[wr_ptr_q]   <= rd_addr_in;
      data_mem_q[wr_ptr_q] <= sel_data;
    end
  end

  assign rf_wr_en_out   = head_en;
  assign rf_rd_addr_out = head_en ? rd_mem_q[rd_ptr_q]   : 5'd0;
  assign rf_wr_data_out = head_en ? data_mem_q[rd_ptr_q] : '0;
  assign wb_count_out   = count_q;

`ifdef MSRV32_WB_FWD_EN
  // Walk oldest to youngest so the entry nearest the write pointer wins.
  always_comb begin
    fwd_hit_out  = 1'b0;
    fwd_data_out = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[ptr_add(rd_ptr_q, i)] &&
          (rd_mem_q[ptr_add(rd_ptr_q, i)] == fwd_addr_in) &&
          (fwd_addr_in != 5'd0)) begin
        fwd_hit_out  = 1'b1;
        fwd_data_out = data_mem_q[ptr_add(rd_ptr_q, i)];
      end
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd   = ^fwd_addr_in;
  assign fwd_hit_out  = 1'b0;
  assign fwd_data_out = '0;
`endif

endmodule

// File: tb/tb_msrv32_wb_queue_unit.sv
// Self-checking bench for msrv32_wb_queue_unit: directed scenarios then random traffic,
// all checked against a queue-based reference model of the pending-write buffer.
module tb_msrv32_wb_queue_unit;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 6;
  localparam int SEL_W   = 3;
  localparam int DEPTH   = 2;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    wbValid;
  logic                    wbReady;
  logic [SEL_W-1:0]        wbSel;
  logic [NUM_SRC*XLEN-1:0] srcData;
  logic [4:0]              rdAddr;
  logic                    rfWrEn;
  logic [4:0]              rfRdAddr;
  logic [XLEN-1:0]         rfWrData;
  logic                    rfAck;
  logic [CNT_W-1:0]        wbCount;
  logic [4:0]              fwdAddr;
  logic                    fwdHit;
  logic [XLEN-1:0]         fwdData;

  msrv32_wb_queue_unit #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W), .DEPTH(DEPTH)
  ) dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .wb_valid_in          (wbValid),
    .wb_ready_out         (wbReady),
    .wb_mux_sel_in        (wbSel),
    .src_data_in          (srcData),
    .rd_addr_in           (rdAddr),
    .rf_wr_en_out         (rfWrEn),
    .rf_rd_addr_out       (rfRdAddr),
    .rf_wr_data_out       (rfWrData),
    .rf_wr_ack_in         (rfAck),
    .wb_count_out         (wbCount),
    .fwd_addr_in          (fwdAddr),
    .fwd_hit_out          (fwdHit),
    .fwd_data_out         (fwdData)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]      rd;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t          modelQ[$];
  logic [XLEN-1:0] srcs[NUM_SRC];
  int              checkCount = 0;
  int              passCount  = 0;
  logic            pendPush;
  logic            pendPop;
  logic            pendRst;
  entry_t          pendEntry;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, actual, expected, $time);
  endtask

  // Drive one cycle's inputs at the falling edge, then check combinational and registered
  // outputs against the model before the next rising edge.
  task automatic applyStimulus(input logic valid, input logic [SEL_W-1:0] sel, input logic [4:0] rd,
                               input logic ack, input logic [4:0] faddr, input logic rstIn);
    logic            expReady, expEn, expHit;
    logic [4:0]      expAddr;
    logic [XLEN-1:0] expData, expFwd, chosen;
    @(negedge clk);
    wbValid = valid; wbSel = sel; rdAddr = rd; rfAck = ack; fwdAddr = faddr; rst = rstIn;
    for (int j = 0; j < NUM_SRC; j++) srcData[j*XLEN +: XLEN] = srcs[j];
    #1;
    expReady = (modelQ.size() != DEPTH);
    expEn    = !rstIn && (modelQ.size() != 0);
    expAddr  = expEn ? modelQ[0].rd : 5'd0;
    expData  = expEn ? modelQ[0].data : '0;
    expHit   = 1'b0;
    expFwd   = '0;
`ifdef MSRV32_WB_FWD_EN
    foreach (modelQ[i]) begin
      if (faddr != 5'd0 && modelQ[i].rd == faddr) begin
        expHit = 1'b1;
        expFwd = modelQ[i].data;
      end
    end
`endif
    checkOutput("ready",   32'(wbReady),  32'(expReady));
    checkOutput("wr_en",   32'(rfWrEn),   32'(expEn));
    checkOutput("rd_addr", 32'(rfRdAddr), 32'(expAddr));
    checkOutput("wr_data", rfWrData,      expData);
    checkOutput("count",   32'(wbCount),  32'(modelQ.size()));
    checkOutput("fwd_hit", 32'(fwdHit),   32'(expHit));
    checkOutput("fwd_dat", fwdData,       expFwd);
    chosen    = (int'(sel) < NUM_SRC) ? srcs[sel] : srcs[0];
    pendRst   = rstIn;
    pendPop   = expEn && ack;
    pendPush  = !rstIn && valid && expReady && (rd != 5'd0);
    pendEntry = '{rd: rd, data: chosen};
  endtask

  task automatic stepClock();
    @(posedge clk);
    if (pendRst) modelQ.delete();
    else begin
      if (pendPop) void'(modelQ.pop_front());
      if (pendPush) modelQ.push_back(pendEntry);
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; wbValid = 1'b0; wbSel = '0; rdAddr = '0; rfAck = 1'b0; fwdAddr = '0; srcData = '0;
    for (int j = 0; j < NUM_SRC; j++) srcs[j] = 32'h1000_0000 + j;

    $display("[TB] reset");
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b1); stepClock();
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b1); stepClock();
    checkOutput("rst_count", 32'(wbCount), 32'd0);
    checkOutput("rst_ready", 32'(wbReady), 32'd1);
    checkOutput("rst_en",    32'(rfWrEn),  32'd0);

    $display("[TB] source select sweep");
    for (int k = 0; k < NUM_SRC; k++) begin
      applyStimulus(1'b1, SEL_W'(k), 5'(k + 1), 1'b1, 5'd0, 1'b0); stepClock();
      checkOutput("sweep_en",   32'(rfWrEn),   32'd1);
      checkOutput("sweep_rd",   32'(rfRdAddr), 32'(k + 1));
      checkOutput("sweep_data", rfWrData,      32'h1000_0000 + k);
    end
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 5'd0, 1'b0); stepClock();
    checkOutput("sweep_drain", 32'(wbCount), 32'd0);

    $display("[TB] out-of-range select");
    srcs[0] = 32'hDEAD_BEEF;
    for (int s = 6; s < 8; s++) begin
      applyStimulus(1'b1, SEL_W'(s), 5'd9, 1'b1, 5'd0, 1'b0); stepClock();
      checkOutput("oor_data", rfWrData, 32'hDEAD_BEEF);
    end
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 5'd0, 1'b0); stepClock();

    $display("[TB] full buffer backpressure");
    applyStimulus(1'b1, 3'd1, 5'd5, 1'b0, 5'd0, 1'b0); stepClock();
    applyStimulus(1'b1, 3'd2, 5'd6, 1'b0, 5'd0, 1'b0); stepClock();
    checkOutput("full_count", 32'(wbCount), 32'd2);
    checkOutput("full_ready", 32'(wbReady), 32'd0);
    applyStimulus(1'b1, 3'd3, 5'd7, 1'b0, 5'd0, 1'b0); stepClock();
    checkOutput("stall_count", 32'(wbCount),  32'd2);
    checkOutput("stall_head",  32'(rfRdAddr), 32'd5);
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 5'd0, 1'b0); stepClock();
    checkOutput("drain1_head",  32'(rfRdAddr), 32'd6);
    checkOutput("drain1_ready", 32'(wbReady),  32'd1);
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 5'd0, 1'b0); stepClock();
    checkOutput("drain2_count", 32'(wbCount), 32'd0);

    $display("[TB] x0 write");
    srcs[0] = 32'hFFFF_FFFF;
    applyStimulus(1'b1, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("x0_ready", 32'(wbReady), 32'd1);
    stepClock();
    checkOutput("x0_count", 32'(wbCount), 32'd0);
    checkOutput("x0_en",    32'(rfWrEn),  32'd0);

    $display("[TB] forwarding");
    srcs[2] = 32'h11;
    applyStimulus(1'b1, 3'd2, 5'd7, 1'b0, 5'd0, 1'b0); stepClock();
    srcs[2] = 32'h22;
    applyStimulus(1'b1, 3'd2, 5'd7, 1'b0, 5'd0, 1'b0); stepClock();
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd7, 1'b0);
`ifdef MSRV32_WB_FWD_EN
    checkOutput("fwd7_hit",  32'(fwdHit), 32'd1);
    checkOutput("fwd7_data", fwdData,     32'h22);
`else
    checkOutput("fwd7_hit",  32'(fwdHit), 32'd0);
    checkOutput("fwd7_data", fwdData,     32'd0);
`endif
    stepClock();
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    checkOutput("fwd0_hit", 32'(fwdHit), 32'd0);
    stepClock();

    $display("[TB] reset while full");
    applyStimulus(1'b0, 3'd0, 5'd0, 1'b1, 5'd7, 1'b1);
    checkOutput("rstcyc_en", 32'(rfWrEn), 32'd0);
    stepClock();
    checkOutput("postrst_count", 32'(wbCount), 32'd0);
    checkOutput("postrst_en",    32'(rfWrEn),  32'd0);
    srcs[4] = 32'hCAFE_0012;
    applyStimulus(1'b1, 3'd4, 5'd12, 1'b1, 5'd0, 1'b0); stepClock();
    checkOutput("postrst_rd",   32'(rfRdAddr), 32'd12);
    checkOutput("postrst_data", rfWrData,      32'hCAFE_0012);

    $display("[TB] random traffic");
    for (int n = 0; n < 600; n++) begin
      for (int j = 0; j < NUM_SRC; j++) srcs[j] = $urandom;
      applyStimulus(1'($urandom_range(0, 3) != 0), SEL_W'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 49) == 0));
      stepClock();
    end

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
